fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Program-counter sequencer for an instruction ROM.  It waits in IDLE for a
// start request, then steps the fetch address through the program (sequential
// increment or PC-relative branch) until a halt is decoded, and parks in DONE
// holding the halt address until the next start.
//
// Parameters
//   A           instruction address width (matches the ROM address width)
//   START_ADDR  program entry address
//
// Ports
//   clk            sole clock, rising edge
//   reset          asynchronous, active-high reset (forces IDLE / START_ADDR)
//   start          begin execution at START_ADDR (sampled in IDLE and DONE)
//   stall          hold the current address; instruction not consumed
//   halt           decoded halt of the current instruction
//   branch_en      taken branch for the current instruction
//   branch_offset  signed two's-complement PC-relative offset (A bits)
//   instr_address  registered address driven to the instruction ROM
//   fetch_valid    instruction at instr_address is consumed this cycle
//   busy           program running
//   done           program has halted
//   cycle_count    16-bit saturating RUN-cycle counter (optional)
//
// Configuration
//   FETCH_CYCLE_COUNT_EN  when defined, adds the cycle_count port and counter.
// -----------------------------------------------------------------------------
module fetch_sequencer #(
   parameter int           A          = 10,
   parameter logic [A-1:0] START_ADDR = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         stall,
   input  logic         halt,
   input  logic         branch_en,
   input  logic [A-1:0] branch_offset,
   output logic [A-1:0] instr_address,
   output logic         fetch_valid,
   output logic         busy,
   output logic         done
`ifdef FETCH_CYCLE_COUNT_EN
   ,
   output logic [15:0]  cycle_count
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state_reg, state_next;
   logic [A-1:0]   addr_reg, addr_next;

   localparam logic [A-1:0] ONE = {{(A-1){1'b0}}, 1'b1};

   // State and address registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_IDLE;
         addr_reg  <= START_ADDR;
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
      end
   end

   // Next-state, next-address and state-decoded outputs.
   // The address adder is A bits wide, so wrap past either end is free.
   always_comb begin
      state_next  = state_reg;
      addr_next   = addr_reg;
      busy        = 1'b0;
      done        = 1'b0;
      fetch_valid = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next = S_RUN;
               addr_next  = START_ADDR;
            end
         end
         S_RUN: begin
            busy        = 1'b1;
            fetch_valid = !stall;
            // stall masks everything; halt beats a simultaneous branch
            if (!stall) begin
               if (halt) begin
                  state_next = S_DONE;
               end else if (branch_en) begin
                  addr_next = addr_reg + branch_offset;
               end else begin
                  addr_next = addr_reg + ONE;
               end
            end
         end
         S_DONE: begin
            done = 1'b1;
            if (start) begin
               state_next = S_RUN;
               addr_next  = START_ADDR;
            end
         end
         default: begin
            state_next = S_IDLE;
            addr_next  = START_ADDR;
         end
      endcase
   end

   assign instr_address = addr_reg;

`ifdef FETCH_CYCLE_COUNT_EN
   logic [15:0] count_reg;

   // Cleared on the edge that enters RUN, counts every RUN edge (stalls and
   // the halting edge included), saturates, and holds outside RUN.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg <= 16'd0;
      end else if (state_reg != S_RUN && state_next == S_RUN) begin
         count_reg <= 16'd0;
      end else if (state_reg == S_RUN && count_reg != 16'hFFFF) begin
         count_reg <= count_reg + 16'd1;
      end
   end

   assign cycle_count = count_reg;
`endif

endmodule
